// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: forward S-box, GF(2^8) xtime, round constants and
// byte/column indexing used by both the encryption and decryption datapaths.
package aes_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } aes_state_e;

  localparam int NR = 10;

  localparam logic [0:255][7:0] SBOX_TBL = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [0:9][7:0] RCON_TBL = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round numbers outside 1..10 have no constant; return 0 so idle decode is benign.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    if (rnd >= 4'd1 && rnd <= 4'd10) return RCON_TBL[rnd - 4'd1];
    return 8'h00;
  endfunction

  // MSB of the low bit-range of state byte (row r, column c); byte 0 sits at [127:120].
  function automatic int bidx(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/mix_columns.sv
// Forward AES MixColumns over the full 128-bit state; pure combinational.
module mix_columns
  import aes_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    data_o = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = data_i[bidx(0, c) -: 8];
      a1 = data_i[bidx(1, c) -: 8];
      a2 = data_i[bidx(2, c) -: 8];
      a3 = data_i[bidx(3, c) -: 8];
      // Rows [02 03 01 01] rotated; 03*x is xtime(x)^x.
      data_o[bidx(0, c) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      data_o[bidx(1, c) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      data_o[bidx(2, c) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      data_o[bidx(3, c) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption: one round per clock, round keys expanded on the fly.
// start is a load request honoured only in IDLE; done pulses once when out updates.
module aes_encrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] out_q, out_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [127:0] nkey, sr, mc, round_out;
  logic [31:0]  w0, w1, w2, w3, temp;

  // Next round key from the current one (words w0..w3, w0 most significant).
  always_comb begin
    w3   = rkey_q[31:0];
    temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon(rnd_q), 24'h0};
    w0   = rkey_q[127:96] ^ temp;
    w1   = rkey_q[95:64] ^ w0;
    w2   = rkey_q[63:32] ^ w1;
    nkey = {w0, w1, w2, w2 ^ w3};
  end

  // SubBytes fused with ShiftRows: row r rotates left by r columns.
  always_comb begin
    sr = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[bidx(r, c) -: 8] = sbox(state_q[bidx(r, (c + r) % 4) -: 8]);
      end
    end
  end

  mix_columns u_mix_columns (
    .data_i (sr),
    .data_o (mc)
  );

  assign round_out = ((rnd_q == 4'(NR)) ? sr : mc) ^ nkey;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    out_d   = out_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = in ^ key;
          rkey_d  = key;
          rnd_d   = 4'd1;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rnd_q == 4'(NR)) begin
          out_d  = round_out;
          done_d = 1'b1;
          rnd_d  = 4'd0;
          fsm_d  = ST_IDLE;
        end else begin
          state_d = round_out;
          rkey_d  = nkey;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rkey_q  <= '0;
      out_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      out_q   <= out_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = (fsm_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: FIPS-197 vectors plus random blocks against a
// byte-array AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes_encrypt_iter;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MC_IN = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] MC_EX = 128'h046681e5e0cb199a48f8d37a2806264c;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] in_blk = '0;
  logic [127:0] out;
  logic         busy, done;
  logic [127:0] mc_in = '0;
  logic [127:0] mc_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] exp_q [$];

  aes_encrypt_iter dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .in    (in_blk),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  mix_columns u_mc (
    .data_i (mc_in),
    .data_o (mc_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b, s;
      for (int x = 1; x < 256; x++)
        if (a != 0 && gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      b = inv;
      s = inv;
      for (int k = 0; k < 4; k++) begin
        b = {b[6:0], b[7]};
        s = s ^ b;
      end
      sbox_m[a] = s ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    logic [7:0]  a0, a1, a2, a3;
    logic [127:0] res = '0;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_m[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] d);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = d[127-32*c -: 8]; a1 = d[119-32*c -: 8];
      a2 = d[111-32*c -: 8]; a3 = d[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_block(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    key = k;
    in_blk = p;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen; lat counts edges since acceptance.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b out=%h, want 0 0 0", busy, done, out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fips_b();
    int lat;
    start_block(KEY_B, PT_B);
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL fips_b_busy: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(lat);
    n_tests++;
    if (lat != 10) begin
      n_fail++;
      $display("FAIL fips_b_latency: got %0d, want 10", lat);
    end
    n_tests++;
    if (out !== CT_B) begin
      n_fail++;
      $display("FAIL fips_b_out: got %h, want %h", out, CT_B);
    end
  endtask

  task automatic test_fips_c1();
    int lat;
    start_block(KEY_C, PT_C);
    wait_done(lat);
    n_tests++;
    if (lat != 10 || out !== CT_C) begin
      n_fail++;
      $display("FAIL fips_c1: lat=%0d out=%h, want 10 %h", lat, out, CT_C);
    end
  endtask

  task automatic test_mix_columns();
    mc_in = MC_IN;
    #1;
    n_tests++;
    if (mc_out !== MC_EX) begin
      n_fail++;
      $display("FAIL mix_columns: got %h, want %h", mc_out, MC_EX);
    end
    n_tests++;
    if (inv_mix(mc_out) !== MC_IN) begin
      n_fail++;
      $display("FAIL mix_roundtrip: got %h, want %h", inv_mix(mc_out), MC_IN);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    exp_q.push_back(CT_B);
    exp_q.push_back(CT_C);
    start_block(KEY_B, PT_B);
    wait_done(lat1);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b busy=%b out=%h, want 1 0 %h", done, busy, out, CT_B);
    end
    key = KEY_C;
    in_blk = PT_C;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_reaccept: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(lat2);
    n_tests++;
    if (lat2 + 1 != 11 || out !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL b2b_second: spacing=%0d out=%h, want 11 %h", lat2 + 1, out, CT_C);
    end
  endtask

  task automatic test_ignored_inputs();
    int cnt = 0;
    start_block(KEY_B, PT_B);
    while (!done && cnt < 40) begin
      start = 1'($urandom_range(0, 1));
      key = {$urandom, $urandom, $urandom, $urandom};
      in_blk = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    n_tests++;
    if (cnt != 10 || out !== CT_B) begin
      n_fail++;
      $display("FAIL ignored_inputs: lat=%0d out=%h, want 10 %h", cnt, out, CT_B);
    end
  endtask

  task automatic test_reset_mid();
    start_block(KEY_C, PT_C);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b done=%b out=%h, want 0 0 0", busy, done, out);
    end
    @(negedge clk);
    rst = 1'b0;
    test_fips_c1();
  endtask

  task automatic test_random();
    logic [127:0] k, p, exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(ref_encrypt(k, p));
      start_block(k, p);
      wait_done(lat);
      exp = exp_q.pop_front();
      n_tests++;
      if (lat != 10 || out !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: lat=%0d out=%h, want 10 %h", i, lat, out, exp);
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_mix_columns();
    test_back_to_back();
    test_ignored_inputs();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
